// File: rtl/ps2_pkg.sv
// Shared constants, frame-state type and scan-code map for the PS/2 keyboard receiver.
package ps2_pkg;

   // Set-2 prefix bytes
   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // Set-2 make codes recognised by the board
   localparam logic [7:0] SC_0     = 8'h45;
   localparam logic [7:0] SC_1     = 8'h16;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_3     = 8'h26;
   localparam logic [7:0] SC_4     = 8'h25;
   localparam logic [7:0] SC_5     = 8'h2E;
   localparam logic [7:0] SC_6     = 8'h36;
   localparam logic [7:0] SC_7     = 8'h3D;
   localparam logic [7:0] SC_8     = 8'h3E;
   localparam logic [7:0] SC_9     = 8'h46;
   localparam logic [7:0] SC_H     = 8'h33;
   localparam logic [7:0] SC_F     = 8'h2B;
   localparam logic [7:0] SC_T     = 8'h2C;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   // Control bytes handed to the microcontroller
   localparam logic [7:0] CTL_CR    = 8'h0D;
   localparam logic [7:0] CTL_ESC   = 8'h1B;
   localparam logic [7:0] CTL_BS    = 8'h08;
   localparam logic [7:0] CTL_UP    = 8'h11;
   localparam logic [7:0] CTL_DOWN  = 8'h12;
   localparam logic [7:0] CTL_LEFT  = 8'h13;
   localparam logic [7:0] CTL_RIGHT = 8'h14;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

   typedef struct packed {
      logic       valid;
      logic [7:0] code;
   } key_map_t;

   // Translate a make code into its ASCII/control byte; valid=0 for unmapped codes.
   function automatic key_map_t map_scan(input logic [7:0] sc, input logic ext);
      key_map_t m;
      m.valid = 1'b1;
      m.code  = 8'h00;
      if (ext) begin
         case (sc)
            SC_UP:    m.code = CTL_UP;
            SC_DOWN:  m.code = CTL_DOWN;
            SC_LEFT:  m.code = CTL_LEFT;
            SC_RIGHT: m.code = CTL_RIGHT;
            default:  m.valid = 1'b0;
         endcase
      end else begin
         case (sc)
            SC_0:     m.code = 8'h30;
            SC_1:     m.code = 8'h31;
            SC_2:     m.code = 8'h32;
            SC_3:     m.code = 8'h33;
            SC_4:     m.code = 8'h34;
            SC_5:     m.code = 8'h35;
            SC_6:     m.code = 8'h36;
            SC_7:     m.code = 8'h37;
            SC_8:     m.code = 8'h38;
            SC_9:     m.code = 8'h39;
            SC_H:     m.code = 8'h48;
            SC_F:     m.code = 8'h46;
            SC_T:     m.code = 8'h54;
            SC_ENTER: m.code = CTL_CR;
            SC_ESC:   m.code = CTL_ESC;
            SC_BKSP:  m.code = CTL_BS;
            default:  m.valid = 1'b0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/ps2_receptor_trama.sv
// PS/2 frame receiver: synchronisers, clock glitch filter, frame FSM and mid-frame timeout.
// Emits a one-cycle byte_valid pulse with byte_data for every frame with good parity and stop bit.
module ps2_receptor_trama
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2data,
   input  logic       ps2clk,
   output logic       byte_valid,
   output logic [7:0] byte_data
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    clk_sync, data_sync;
   logic          clk_filt, fall_edge, sample, timeout;
   logic [FW-1:0] filt_cnt;
   logic [TW-1:0] to_cnt;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;
   logic          parity_bit;
   ps2_state_t    state, next_state;

   assign sample  = data_sync[1];
   assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Two-flop synchronisers for both PS/2 lines
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the sync flops reset to the idle bus level (high) so releasing reset never fakes an edge.
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2clk};
         data_sync <= {data_sync[0], ps2data};
      end
   end

   // Glitch filter: accept a new clock level after FILTER_LEN identical samples; flag falling edges
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_filt  <= 1'b1;
         filt_cnt  <= '0;
         fall_edge <= 1'b0;
      end else begin
         fall_edge <= 1'b0;
         if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt  <= clk_sync[1];
            filt_cnt  <= '0;
            fall_edge <= clk_filt;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   // Idle-cycle counter; restarts on every edge and stays cleared in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (state == IDLE || fall_edge) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   // Frame state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic: edges advance the frame, a timeout abandons it
   always_comb begin
      // NOTE: default first so every path assigns next_state and no latch is inferred.
      next_state = state;
      if (fall_edge) begin
         case (state)
            IDLE:    if (!sample) next_state = DATA;
            DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
            PARITY:  next_state = STOP;
            STOP:    next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end else if (timeout) begin
         next_state = IDLE;
      end
   end

   // Frame datapath: LSB-first shift register, bit counter and parity capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift      <= '0;
         bit_cnt    <= '0;
         parity_bit <= 1'b0;
      end else if (fall_edge) begin
         case (state)
            IDLE: bit_cnt <= '0;
            DATA: begin
               shift   <= {sample, shift[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
            PARITY:  parity_bit <= sample;
            default: ;
         endcase
      end
   end

   // Output: validate on the stop edge (stop bit high, odd parity over data+parity)
   always_comb begin
      // NOTE: combinational blocks use blocking '=', clocked blocks use '<='.
      byte_valid = 1'b0;
      byte_data  = shift;
      if (state == STOP && fall_edge && sample && (^{parity_bit, shift}))
         byte_valid = 1'b1;
   end

endmodule

// File: rtl/receptor_teclado_ps2.sv
// PS/2 keyboard receiver top: prefix/break decoding, scan-code map and key FIFO read through port_id.
module receptor_teclado_ps2
   import ps2_pkg::*;
#(
   parameter logic [7:0] PORT_ASCII     = 8'h02,
   parameter int         FILTER_LEN     = 8,
   parameter int         TIMEOUT_CYCLES = 200000,
   parameter int         FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2data,
   input  logic       ps2clk,
   input  logic [7:0] port_id,
   input  logic       read_strobe,
   output logic [7:0] ascii_code
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          ext, brk;
   logic          map_valid;
   logic [7:0]    map_data;
   key_map_t      mapped;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          full, empty, push, pop;

   ps2_receptor_trama #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_trama (
      .clk        (clk),
      .reset      (reset),
      .ps2data    (ps2data),
      .ps2clk     (ps2clk),
      .byte_valid (byte_valid),
      .byte_data  (byte_data)
   );

   assign mapped = map_scan(byte_data, ext);
   assign full   = (count == CW'(FIFO_DEPTH));
   assign empty  = (count == '0);
   assign pop    = read_strobe && (port_id == PORT_ASCII) && !empty;
   assign push   = map_valid && (!full || pop);

   // Decoder: track E0/F0 prefixes, drop break sequences, register the mapped key
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ext       <= 1'b0;
         brk       <= 1'b0;
         map_valid <= 1'b0;
         map_data  <= '0;
      end else begin
         map_valid <= 1'b0;
         if (byte_valid) begin
            if (byte_data == PS2_EXT) begin
               ext <= 1'b1;
            end else if (byte_data == PS2_BRK) begin
               brk <= 1'b1;
            end else begin
               if (!brk) begin
                  map_valid <= mapped.valid;
                  map_data  <= mapped.code;
               end
               ext <= 1'b0;
               brk <= 1'b0;
            end
         end
      end
   end

   // FIFO storage write
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; count/pointers define which entries are meaningful.
      if (push) mem[wr_ptr] <= map_data;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign ascii_code = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_receptor_teclado_ps2.sv
// Directed bench for receptor_teclado_ps2: drives PS/2 frames bit by bit and pops keys via port 02.
module tb_receptor_teclado_ps2;

   localparam int HALF_BIT = 20;
   localparam int TO       = 1500;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2data = 1'b1;
   logic       ps2clk = 1'b1;
   logic [7:0] port_id = 8'h02;
   logic       read_strobe = 1'b0;
   logic [7:0] ascii_code;
   logic       found;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   receptor_teclado_ps2 #(
      .PORT_ASCII     (8'h02),
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (TO),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ps2data     (ps2data),
      .ps2clk      (ps2clk),
      .port_id     (port_id),
      .read_strobe (read_strobe),
      .ascii_code  (ascii_code)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // One PS/2 bit: data set while clock high, then clock low, then high again
   task automatic ps2_bit(input logic b);
      ps2data = b;
      repeat (HALF_BIT) @(posedge clk);
      ps2clk = 1'b0;
      repeat (HALF_BIT) @(posedge clk);
      ps2clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic good_par);
      logic p;
      p = ~^b;
      if (!good_par) p = ~p;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(p);
      ps2_bit(1'b1);
      repeat (2 * HALF_BIT) @(posedge clk);
   endtask

   task automatic expect_head(input string tag, input logic [7:0] exp);
      @(negedge clk);
      check(tag, ascii_code, exp);
   endtask

   // Check the head during the strobe cycle, then pop it
   task automatic read_key(input string tag, input logic [7:0] exp);
      @(negedge clk);
      check(tag, ascii_code, exp);
      read_strobe = 1'b1;
      @(negedge clk);
      read_strobe = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(posedge clk);
      expect_head("reset_head", 8'h00);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      expect_head("after_reset", 8'h00);

      // Single key '1'
      send_frame(8'h16, 1'b1);
      read_key("key_16", 8'h31);
      expect_head("key_16_empty", 8'h00);

      // Make, break, make: only one entry
      send_frame(8'h16, 1'b1);
      send_frame(8'hF0, 1'b1);
      send_frame(8'h16, 1'b1);
      read_key("brk_seq", 8'h31);
      expect_head("brk_seq_empty", 8'h00);

      // Bad parity frame, then a good one
      send_frame(8'h1E, 1'b0);
      expect_head("bad_parity", 8'h00);
      send_frame(8'h45, 1'b1);
      read_key("after_bad", 8'h30);
      expect_head("after_bad_empty", 8'h00);

      // Extended make, extended break, unmapped
      send_frame(8'hE0, 1'b1);
      send_frame(8'h75, 1'b1);
      read_key("ext_up", 8'h11);
      expect_head("ext_up_empty", 8'h00);
      send_frame(8'hE0, 1'b1);
      send_frame(8'hF0, 1'b1);
      send_frame(8'h75, 1'b1);
      expect_head("ext_brk", 8'h00);
      send_frame(8'h1C, 1'b1);
      expect_head("unmapped", 8'h00);

      // Overflow: fifth key dropped
      send_frame(8'h16, 1'b1);
      send_frame(8'h1E, 1'b1);
      send_frame(8'h26, 1'b1);
      send_frame(8'h25, 1'b1);
      send_frame(8'h2E, 1'b1);
      read_key("full_0", 8'h31);
      read_key("full_1", 8'h32);
      read_key("full_2", 8'h33);
      read_key("full_3", 8'h34);
      expect_head("full_empty", 8'h00);

      // Push and pop in the same cycle while full
      send_frame(8'h16, 1'b1);
      send_frame(8'h1E, 1'b1);
      send_frame(8'h26, 1'b1);
      send_frame(8'h25, 1'b1);
      found = 1'b0;
      fork
         send_frame(8'h36, 1'b1);
         begin
            for (int i = 0; i < 2000; i++) begin
               @(negedge clk);
               if (dut.map_valid) begin
                  found = 1'b1;
                  break;
               end
            end
            check("pushpop_seen", {7'd0, found}, 8'h01);
            if (found) begin
               check("pushpop_head", ascii_code, 8'h31);
               read_strobe = 1'b1;
               @(negedge clk);
               read_strobe = 1'b0;
            end
         end
      join
      read_key("pushpop_0", 8'h32);
      read_key("pushpop_1", 8'h33);
      read_key("pushpop_2", 8'h34);
      read_key("pushpop_3", 8'h36);
      expect_head("pushpop_empty", 8'h00);

      // Truncated frame followed by silence longer than the timeout
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      repeat (TO + 200) @(posedge clk);
      expect_head("timeout_empty", 8'h00);
      send_frame(8'h45, 1'b1);
      read_key("after_timeout", 8'h30);
      expect_head("after_timeout_empty", 8'h00);

      // Reset in the middle of a frame with a key queued
      send_frame(8'h16, 1'b1);
      expect_head("pre_reset_head", 8'h31);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      reset = 1'b1;
      expect_head("mid_reset", 8'h00);
      repeat (5) @(posedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      expect_head("post_reset", 8'h00);
      send_frame(8'h45, 1'b1);
      read_key("post_reset_key", 8'h30);
      expect_head("post_reset_empty", 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/receptor_teclado_ps2.md
# receptor_teclado_ps2

PS/2 keyboard receiver that feeds the microcontroller input-port mux on the digital clock board. It deserialises PS/2 device-to-host frames and checks them. It drops break (key-release) sequences, translates a fixed set of set-2 make codes to ASCII/control bytes, and queues them in a small FIFO. The microcontroller pops keys with an INPUT instruction on port `PORT_ASCII`.

## Interface
- `PORT_ASCII`, 8'h02, port_id value that selects and pops the key FIFO
- `FILTER_LEN`, 8, consecutive equal samples needed to accept a new ps2clk level
- `TIMEOUT_CYCLES`, 200000, idle clk cycles mid-frame before abort (2 ms at 100 MHz)
- `FIFO_DEPTH`, 4, key queue entries (power of 2)

- `clk` in 1: system clock, sole clock domain
- `reset` in 1: asynchronous, active-high; clears all state
- `ps2data` in 1: PS/2 data line, asynchronous
- `ps2clk` in 1: PS/2 clock line, asynchronous, sampled only (never driven)
- `port_id` in 8: microcontroller port address
- `read_strobe` in 1: one-cycle INPUT strobe
- `ascii_code` out 8: FIFO head byte; 8'h00 when empty

## Operation
- Sync: `ps2clk` and `ps2data` each pass through 2 flops. Glitch filter on clk: the filtered level changes only after `FILTER_LEN` identical samples. A falling edge of the filtered clk is the sample event; data is taken from the synchronised `ps2data` at that event.
- Frame FSM:
  - IDLE: on an edge with data=0 (start bit) → DATA; with data=1, stay.
  - DATA: shift 8 bits, LSB first → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: on the edge, the byte is valid iff stop=1 and the 9 bits have odd parity; either way → IDLE.
- Invalid frame: byte discarded silently; prefix flags unchanged.
- Timeout: in any state but IDLE, `TIMEOUT_CYCLES` cycles with no edge → IDLE; partial byte discarded. Counter restarts on every edge.
- Decoder flags:
  - 8'hE0 sets `ext`. 8'hF0 sets `brk`. Neither is enqueued.
  - Any other byte: if `brk`, discard. Otherwise map using `ext`. Then clear both flags.
- Map, non-extended:
  - 45,16,1E,26,25,2E,36,3D,3E,46 → '0'..'9' (30..39)
  - 33→48 'H', 2B→46 'F', 2C→54 'T'
  - 5A→0D, 76→1B, 66→08
- Map, extended: 75→11, 72→12, 6B→13, 74→14.
- Unmapped codes are discarded.
- FIFO:
  - Push a mapped byte when not full. When full, the byte is dropped.
  - Pop when `read_strobe`=1 and `port_id`=`PORT_ASCII` and not empty. A pop on empty is ignored.
  - Push and pop in the same cycle: both are performed, count unchanged; this also applies when full.
- `ascii_code` = head entry, or 8'h00 when empty. It is held stable while `port_id` holds.

## Timing
- Reset values: `ascii_code`=8'h00, FSM=IDLE, filtered clk=1, ext=brk=0, FIFO empty, timeout counter 0.
- Edge detection lag: 2 + `FILTER_LEN` + 1 clk after the raw `ps2clk` falls.
- Decode latency: the byte is validated on the STOP-edge cycle, decoded/mapped in the next cycle, and written to the FIFO on the cycle after that. `ascii_code` shows the new head at most 3 clk after the stop edge is detected.
- Pop: applied on the clk edge that samples `read_strobe`=1. `ascii_code` shows the next entry (or 00) the following cycle. The microcontroller reads the old head during the strobe cycle.
- Reset mid-frame or mid-prefix: immediate return to reset values; no partial key survives.

## Structure
- Package `ps2_pkg`:
  - prefix constants `PS2_EXT`=E0, `PS2_BRK`=F0
  - scan-code and control-byte constants
  - state typedef {IDLE, DATA, PARITY, STOP}
  - mapping function
- Sub-module `ps2_receptor_trama`: sync, filter, frame FSM and timeout. Outputs `byte_valid`/`byte_data` pulses. The top level holds the decoder flags, the map and the FIFO.

## Test plan
- Frame 16 (parity 0) → `ascii_code`=31 with port_id=02. Pulse read_strobe → `ascii_code`=00.
- Sequence 16, F0, 16 → exactly one entry 31; a second read gives 00.
- Frame 1E with parity bit 0 (bad) → nothing queued. The following valid frame 45 → 30.
- Sequence E0, 75 → 11. Sequence E0, F0, 75 → nothing queued. Frame 1C (unmapped) → nothing queued.
- Keys 16,1E,26,25,2E with no reads → reads return 31,32,33,34, then 00 (fifth key dropped). A simultaneous push+pop when full keeps 4 entries.
- 4 clk edges then silence > `TIMEOUT_CYCLES` → IDLE; next full frame 45 → 30. Assert reset mid-frame → `ascii_code`=00 and the FIFO is empty after release.
